// File: rtl/fp_spi_pkg.sv
// Shared command/response codes and FSM encoding for the front-panel SPI link.
package fp_spi_pkg;

    localparam logic [7:0] CMD_NOP            = 8'h00;
    localparam logic [7:0] CMD_WRITE_LED      = 8'h01;
    localparam logic [7:0] CMD_READ_CHIP_ID   = 8'h06;
    localparam logic [7:0] CMD_READ_VENDOR_ID = 8'h19;

    localparam logic [7:0] RESP_CHIP_ID   = 8'h71;
    localparam logic [7:0] RESP_VENDOR_ID = 8'hAE;
    localparam logic [7:0] RESP_ACK       = 8'h01;
    localparam logic [7:0] RESP_NAK       = 8'h80;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_GAP   = 3'd3,
        ST_HOLD  = 3'd4,
        ST_FIN   = 3'd5
    } fsm_state_t;

    // A zero-length stage still occupies one cycle, so its terminal count saturates at 0.
    function automatic int stage_last(input int cycles);
        return (cycles > 0) ? cycles - 1 : 0;
    endfunction

endpackage

// File: rtl/fp_spi_host_sckgen.sv
// SCK divider: CLK_DIV system cycles per half-period, SCK low while disabled.
module fp_spi_host_sckgen #(
    parameter int CLK_DIV = 4
) (
    input  logic SCLK,
    input  logic NRST,
    input  logic en,
    output logic sck,
    output logic rise,
    output logic fall
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0] div_cnt;
    logic             tc;

    assign tc   = (div_cnt == DIV_W'(CLK_DIV - 1));
    // Strobes are high in the cycle whose closing edge moves SCK.
    assign rise = en && tc && !sck;
    assign fall = en && tc && sck;

    // NOTE: sequential state uses non-blocking assignments so every register
    // sees the pre-edge values of its neighbours.
    always_ff @(posedge SCLK or posedge NRST) begin
        if (NRST) begin
            div_cnt <= '0;
            sck     <= 1'b0;
        end else if (!en) begin
            div_cnt <= '0;
            sck     <= 1'b0;
        end else if (tc) begin
            div_cnt <= '0;
            sck     <= !sck;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/fp_spi_host.sv
// Host-side SPI initiator: one command byte then one data byte per START,
// LSB first, SCK idle low; the response is captured during the data byte.
module fp_spi_host
    import fp_spi_pkg::*;
#(
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 2,
    parameter int BYTE_GAP = 4,
    parameter int CS_HOLD  = 2
) (
    input  logic       SCLK,
    input  logic       NRST,
    input  logic       START,
    input  logic [7:0] CMD,
    input  logic [7:0] WDATA,
    output logic       BUSY,
    output logic       DONE,
    output logic [7:0] RDATA,
    output logic       RSP_NAK,
    output logic       SCK,
    output logic       MOSI,
    input  logic       MISO,
    output logic       SS
);

    localparam int SETUP_LAST = stage_last(CS_SETUP);
    localparam int GAP_LAST   = stage_last(BYTE_GAP);
    localparam int HOLD_LAST  = stage_last(CS_HOLD);
    localparam int CNT_MAX    = (SETUP_LAST > GAP_LAST)
                              ? ((SETUP_LAST > HOLD_LAST) ? SETUP_LAST : HOLD_LAST)
                              : ((GAP_LAST > HOLD_LAST) ? GAP_LAST : HOLD_LAST);
    localparam int CNT_W      = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;

    fsm_state_t       state, state_next;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       rise_cnt;
    logic             byte1;
    logic [7:0]       tx_sr;
    logic [7:0]       wdata_q;
    logic [7:0]       rx_sr;
    logic             rise, fall;
    logic             accept, last_fall, timed_state, active_next, hold_exit;

    fp_spi_host_sckgen #(
        .CLK_DIV (CLK_DIV)
    ) u_sckgen (
        .SCLK (SCLK),
        .NRST (NRST),
        .en   (state == ST_SHIFT),
        .sck  (SCK),
        .rise (rise),
        .fall (fall)
    );

    assign accept      = (state == ST_IDLE) && START;
    assign last_fall   = fall && (rise_cnt == 4'd8);
    assign timed_state = (state inside {ST_SETUP, ST_GAP, ST_HOLD});
    assign active_next = (state_next inside {ST_SETUP, ST_SHIFT, ST_GAP, ST_HOLD});
    assign hold_exit   = (state == ST_HOLD) && (state_next == ST_FIN);
    // tx_sr[0] is the wire bit, so MOSI is a plain register output.
    assign MOSI        = tx_sr[0];

    always_ff @(posedge SCLK or posedge NRST) begin
        if (NRST) state <= ST_IDLE;
        else      state <= state_next;
    end

    // NOTE: state_next gets its default before the case, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (START)                      state_next = ST_SETUP;
            ST_SETUP: if (cnt == CNT_W'(SETUP_LAST))  state_next = ST_SHIFT;
            ST_SHIFT: if (last_fall)                  state_next = byte1 ? ST_HOLD : ST_GAP;
            ST_GAP:   if (cnt == CNT_W'(GAP_LAST))    state_next = ST_SHIFT;
            ST_HOLD:  if (cnt == CNT_W'(HOLD_LAST))   state_next = ST_FIN;
            ST_FIN:                                   state_next = ST_IDLE;
            default:                                  state_next = ST_IDLE;
        endcase
    end

    // NOTE: the asynchronous reset clears every datapath register too, so an
    // aborted transfer leaves no stale bits behind for the next request.
    always_ff @(posedge SCLK or posedge NRST) begin
        if (NRST) begin
            cnt      <= '0;
            rise_cnt <= '0;
            byte1    <= 1'b0;
            tx_sr    <= '0;
            wdata_q  <= '0;
            rx_sr    <= '0;
        end else begin
            if (timed_state && (state_next == state)) cnt <= cnt + 1'b1;
            else                                      cnt <= '0;

            if (accept) begin
                tx_sr    <= CMD;
                wdata_q  <= WDATA;
                rise_cnt <= '0;
                byte1    <= 1'b0;
            end else if (rise) begin
                rise_cnt <= rise_cnt + 1'b1;
            end else if (fall) begin
                if (last_fall) begin
                    rise_cnt <= '0;
                    // Data byte bit 0 goes on the wire as the gap starts; after
                    // the data byte the last bit is simply held.
                    if (!byte1) begin
                        tx_sr <= wdata_q;
                        byte1 <= 1'b1;
                    end
                end else begin
                    tx_sr <= {1'b0, tx_sr[7:1]};
                end
                // Target drove MISO at the preceding rise; command-byte samples are dropped.
                if (byte1) rx_sr <= {MISO, rx_sr[7:1]};
            end else if (hold_exit) begin
                tx_sr <= '0;
            end
        end
    end

    always_ff @(posedge SCLK or posedge NRST) begin
        if (NRST) begin
            SS      <= 1'b1;
            BUSY    <= 1'b0;
            DONE    <= 1'b0;
            RDATA   <= '0;
            RSP_NAK <= 1'b0;
        end else begin
            SS   <= !active_next;
            BUSY <= (state_next != ST_IDLE);
            DONE <= (state_next == ST_FIN);
            if (hold_exit) begin
                RDATA   <= rx_sr;
                RSP_NAK <= (rx_sr == RESP_NAK);
            end
        end
    end

endmodule

// File: tb/tb_fp_spi_host.sv
// Directed bench for fp_spi_host: default-parameter instance plus a CLK_DIV=1,
// BYTE_GAP=0 instance, each talking to a behavioural front-panel target.
module tb_fp_spi_host;
    import fp_spi_pkg::*;

    logic            SCLK    = 1'b0;
    logic            NRST    = 1'b0;
    logic [1:0]      start   = '0;
    logic [1:0][7:0] cmd     = '0;
    logic [1:0][7:0] wdata   = '0;
    logic [1:0]      tgt_rst = '0;

    wire [1:0]       busy_w, done_w, nak_w, sck_w, mosi_w, miso_w, ss_w;
    wire [1:0][7:0]  rdata_w;

    int checks   = 0;
    int failures = 0;

    always #5 SCLK = ~SCLK;

    function automatic logic [7:0] resp_of(input logic [7:0] c);
        case (c)
            CMD_READ_CHIP_ID:       return RESP_CHIP_ID;
            CMD_READ_VENDOR_ID:     return RESP_VENDOR_ID;
            CMD_WRITE_LED, CMD_NOP: return RESP_ACK;
            default:                return RESP_NAK;
        endcase
    endfunction

    // Target model and wire monitor, one per DUT instance.
    for (genvar g = 0; g < 2; g++) begin : tgt
        localparam int CDV = (g == 0) ? 4 : 1;
        logic [7:0] cmd_rx = '0;
        logic [7:0] dat_rx = '0;
        logic [7:0] led    = '0;
        logic       miso_q = 1'b0;
        int         bitn   = 0;
        wire  [7:0] resp_v = resp_of(cmd_rx);
        int         done_cnt = 0, ss_viol = 0, width_viol = 0, rises = 0;
        int         hi_run = 0, lo_run = 0;
        logic       prev_sck = 1'b0, prev_ss = 1'b1;

        assign miso_w[g] = miso_q;

        // Bit counter deliberately ignores SS, like the real target.
        always @(posedge sck_w[g] or posedge tgt_rst[g]) begin
            if (tgt_rst[g]) begin
                bitn   <= 0;
                miso_q <= 1'b0;
            end else begin
                bitn <= (bitn + 1) % 16;
                if (bitn < 8) begin
                    cmd_rx[bitn[2:0]] <= mosi_w[g];
                    miso_q            <= 1'b1;
                end else begin
                    dat_rx[bitn[2:0]] <= mosi_w[g];
                    miso_q            <= resp_v[bitn[2:0]];
                    if (bitn == 15 && cmd_rx == CMD_WRITE_LED)
                        led <= {mosi_w[g], dat_rx[6:0]};
                end
            end
        end

        always @(negedge SCLK) begin
            prev_sck <= sck_w[g];
            prev_ss  <= ss_w[g];
            if (NRST) begin
                hi_run <= 0;
                lo_run <= 0;
            end else begin
                if (done_w[g]) done_cnt <= done_cnt + 1;
                if (sck_w[g]) begin
                    hi_run <= hi_run + 1;
                    lo_run <= 0;
                    if (!prev_sck) begin
                        rises <= rises + 1;
                        if (ss_w[g] || prev_ss) ss_viol <= ss_viol + 1;
                        if ((bitn % 8) != 1 && lo_run != CDV) width_viol <= width_viol + 1;
                    end
                end else begin
                    lo_run <= lo_run + 1;
                    hi_run <= 0;
                    if (prev_sck && hi_run != CDV) width_viol <= width_viol + 1;
                end
            end
        end
    end

    fp_spi_host u_dut0 (
        .SCLK    (SCLK),
        .NRST    (NRST),
        .START   (start[0]),
        .CMD     (cmd[0]),
        .WDATA   (wdata[0]),
        .BUSY    (busy_w[0]),
        .DONE    (done_w[0]),
        .RDATA   (rdata_w[0]),
        .RSP_NAK (nak_w[0]),
        .SCK     (sck_w[0]),
        .MOSI    (mosi_w[0]),
        .MISO    (miso_w[0]),
        .SS      (ss_w[0])
    );

    fp_spi_host #(
        .CLK_DIV  (1),
        .BYTE_GAP (0)
    ) u_dut1 (
        .SCLK    (SCLK),
        .NRST    (NRST),
        .START   (start[1]),
        .CMD     (cmd[1]),
        .WDATA   (wdata[1]),
        .BUSY    (busy_w[1]),
        .DONE    (done_w[1]),
        .RDATA   (rdata_w[1]),
        .RSP_NAK (nak_w[1]),
        .SCK     (sck_w[1]),
        .MOSI    (mosi_w[1]),
        .MISO    (miso_w[1]),
        .SS      (ss_w[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Returns at the falling edge inside the DONE cycle; lat counts cycles from acceptance.
    task automatic run_txn(input int u, input logic [7:0] c, input logic [7:0] d,
                           input bit spur, input logic [7:0] prev, output int lat);
        int n;
        @(negedge SCLK);
        cmd[u]   = c;
        wdata[u] = d;
        start[u] = 1'b1;
        @(negedge SCLK);
        start[u] = 1'b0;
        cmd[u]   = ~c;
        wdata[u] = ~d;
        check("busy_after_accept", busy_w[u], 1);
        n = 1;
        while (!done_w[u] && n < 400) begin
            @(negedge SCLK);
            n++;
            if (spur && n == 20) begin
                start[u] = 1'b1;
                cmd[u]   = CMD_READ_VENDOR_ID;
            end
            if (spur && n == 21) start[u] = 1'b0;
            if (n == 50) check("rdata_held", rdata_w[u], prev);
        end
        if (n >= 400) check("done_timeout", done_w[u], 1);
        lat = n;
    endtask

    initial begin
        int lat, r0, d0, n;
        #1 NRST = 1'b1;
        repeat (3) @(negedge SCLK);
        check("rst_ss",    ss_w[0],    1);
        check("rst_sck",   sck_w[0],   0);
        check("rst_mosi",  mosi_w[0],  0);
        check("rst_busy",  busy_w[0],  0);
        check("rst_done",  done_w[0],  0);
        check("rst_rdata", rdata_w[0], 8'h00);
        check("rst_nak",   nak_w[0],   0);
        NRST = 1'b0;
        repeat (2) @(negedge SCLK);

        // Chip ID read at default timing.
        r0 = tgt[0].rises;
        d0 = tgt[0].done_cnt;
        run_txn(0, CMD_READ_CHIP_ID, 8'h00, 1'b0, 8'h00, lat);
        check("chipid_latency", lat, 137);
        check("chipid_rdata", rdata_w[0], 8'h71);
        check("chipid_nak", nak_w[0], 0);
        repeat (3) @(negedge SCLK);
        check("chipid_pulses", tgt[0].rises - r0, 16);
        check("chipid_one_done", tgt[0].done_cnt - d0, 1);
        check("idle_ss", ss_w[0], 1);
        check("idle_mosi", mosi_w[0], 0);

        // LED write: wire order of both bytes checked through the target's capture.
        run_txn(0, CMD_WRITE_LED, 8'hA5, 1'b0, 8'h71, lat);
        check("led_rdata", rdata_w[0], 8'h01);
        check("led_wire_cmd", tgt[0].cmd_rx, 8'h01);
        check("led_wire_data", tgt[0].dat_rx, 8'hA5);
        check("led_port", tgt[0].led, 8'hA5);
        repeat (2) @(negedge SCLK);

        run_txn(0, CMD_READ_VENDOR_ID, 8'h00, 1'b0, 8'h01, lat);
        check("vendor_rdata", rdata_w[0], 8'hAE);
        check("vendor_nak", nak_w[0], 0);
        repeat (2) @(negedge SCLK);

        run_txn(0, 8'h33, 8'h00, 1'b0, 8'hAE, lat);
        check("unknown_rdata", rdata_w[0], 8'h80);
        check("unknown_nak", nak_w[0], 1);
        repeat (2) @(negedge SCLK);

        // START while busy and START in the FIN cycle are both ignored.
        d0 = tgt[0].done_cnt;
        run_txn(0, CMD_READ_CHIP_ID, 8'h00, 1'b1, 8'h80, lat);
        check("busy_start_latency", lat, 137);
        check("busy_start_rdata", rdata_w[0], 8'h71);
        check("busy_start_nak", nak_w[0], 0);
        cmd[0]   = CMD_READ_VENDOR_ID;
        start[0] = 1'b1;
        @(negedge SCLK);
        start[0] = 1'b0;
        check("fin_start_ignored", busy_w[0], 0);
        repeat (3) @(negedge SCLK);
        check("fin_start_still_idle", busy_w[0], 0);
        check("busy_start_one_done", tgt[0].done_cnt - d0, 1);

        // Reset after the 5th rise of the data byte.
        @(negedge SCLK);
        cmd[0]   = CMD_READ_CHIP_ID;
        start[0] = 1'b1;
        @(negedge SCLK);
        start[0] = 1'b0;
        n = 0;
        while (tgt[0].bitn != 13 && n < 400) begin
            @(negedge SCLK);
            n++;
        end
        check("abort_reached_rise13", tgt[0].bitn, 13);
        d0   = tgt[0].done_cnt;
        NRST = 1'b1;
        #1;
        check("abort_ss",    ss_w[0],    1);
        check("abort_sck",   sck_w[0],   0);
        check("abort_busy",  busy_w[0],  0);
        check("abort_done",  done_w[0],  0);
        check("abort_mosi",  mosi_w[0],  0);
        check("abort_rdata", rdata_w[0], 8'h00);
        repeat (3) @(negedge SCLK);
        NRST = 1'b0;
        repeat (150) @(negedge SCLK);
        check("abort_no_done", tgt[0].done_cnt - d0, 0);
        check("abort_idle_ss", ss_w[0], 1);
        tgt_rst[0] = 1'b1;
        #1 tgt_rst[0] = 1'b0;
        run_txn(0, CMD_READ_CHIP_ID, 8'h00, 1'b0, 8'h00, lat);
        check("after_abort_rdata", rdata_w[0], 8'h71);
        check("after_abort_latency", lat, 137);

        // Fastest divider with a zero gap, which still lasts one cycle.
        run_txn(1, CMD_READ_CHIP_ID, 8'h00, 1'b0, 8'h00, lat);
        check("fast_latency", lat, 38);
        check("fast_chipid_rdata", rdata_w[1], 8'h71);
        repeat (2) @(negedge SCLK);
        run_txn(1, CMD_WRITE_LED, 8'h3C, 1'b0, 8'h71, lat);
        check("fast_led_rdata", rdata_w[1], 8'h01);
        check("fast_led_port", tgt[1].led, 8'h3C);
        repeat (3) @(negedge SCLK);
        check("fast_pulses", tgt[1].rises, 32);

        check("ss_guard_dut0", tgt[0].ss_viol, 0);
        check("ss_guard_dut1", tgt[1].ss_viol, 0);
        check("sck_width_dut0", tgt[0].width_viol, 0);
        check("sck_width_dut1", tgt[1].width_viol, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
